led_pattern_sequencer: RTL

- Controller that plays an LED animation stored in an external synchronous-read pattern ROM/BRAM.
- Generates ROM addresses within a selectable window (base, frame count). Registers each fetched frame onto the LEDs and holds it for a programmable number of cycles.
- Supports one-shot and loop playback with start/stop control.
- Sits between the Clockworks-generated clock/reset and the pattern memory. Replaces a free-running PC counter.

---
 rtl/led_pattern_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/led_pattern_sequencer.sv
// Plays a windowed LED animation out of a synchronous-read pattern ROM, one hold period per frame.
// Define LED_SEQ_PINGPONG_EN to make loop playback bounce back and forth across the window.
//
// state | meaning
// IDLE  | waiting for start; leds keep the last frame
// FETCH | ROM read strobe for address base+idx
// WAIT  | ROM data returns; captured onto leds at the end of the cycle
// HOLD  | hold timer counts down, then pick the next frame
// DONE  | one-cycle completion pulse
module led_pattern_sequencer #(
  parameter int AW = 5,
  parameter int DW = 5,
  parameter int PW = 21
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic          stop,
  input  logic          loop,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] len,
  input  logic [PW-1:0] period,
  output logic          rom_en,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic [DW-1:0] leds,
  output logic          busy,
  output logic          done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW-1:0] last_q, last_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          loop_q, loop_d;
  logic [PW-1:0] period_q, period_d;
  logic [PW-1:0] timer_q, timer_d;
  logic [DW-1:0] leds_q, leds_d;
  logic [AW-1:0] next_idx;
`ifdef LED_SEQ_PINGPONG_EN
  logic          dir_up_q, dir_up_d;
`endif

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    last_d   = last_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    loop_d   = loop_q;
    period_d = period_q;
    timer_d  = timer_q;
    leds_d   = leds_q;
    next_idx = idx_q + AW'(1);
`ifdef LED_SEQ_PINGPONG_EN
    dir_up_d = dir_up_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          base_d   = base;
          last_d   = (len == '0) ? '0 : len - AW'(1);
          loop_d   = loop;
          period_d = period;
          idx_d    = '0;
          addr_d   = base;
`ifdef LED_SEQ_PINGPONG_EN
          dir_up_d = 1'b1;
`endif
          state_d  = S_FETCH;
        end
      end
      S_FETCH: state_d = stop ? S_IDLE : S_WAIT;
      S_WAIT: begin
        if (stop) begin
          state_d = S_IDLE;
        end else begin
          leds_d  = rom_data;
          timer_d = period_q;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (timer_q != '0) begin
          timer_d = timer_q - PW'(1);
        end else if (idx_q == last_q && !loop_q) begin
          state_d = S_DONE;
        end else begin
          if (idx_q == last_q) next_idx = '0;
`ifdef LED_SEQ_PINGPONG_EN
          // Bounce only when the window has an interior frame; shorter windows loop plainly.
          if (loop_q && last_q >= AW'(2)) begin
            if (dir_up_q ? (idx_q == last_q) : (idx_q == '0)) dir_up_d = !dir_up_q;
            next_idx = dir_up_d ? idx_q + AW'(1) : idx_q - AW'(1);
          end
`endif
          idx_d   = next_idx;
          addr_d  = base_q + next_idx;
          state_d = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      last_q   <= '0;
      idx_q    <= '0;
      addr_q   <= '0;
      loop_q   <= 1'b0;
      period_q <= '0;
      timer_q  <= '0;
      leds_q   <= '0;
`ifdef LED_SEQ_PINGPONG_EN
      dir_up_q <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      last_q   <= last_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      loop_q   <= loop_d;
      period_q <= period_d;
      timer_q  <= timer_d;
      leds_q   <= leds_d;
`ifdef LED_SEQ_PINGPONG_EN
      dir_up_q <= dir_up_d;
`endif
    end
  end

  assign rom_en   = (state_q == S_FETCH);
  assign rom_addr = addr_q;
  assign leds     = leds_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);

endmodule
